// File: rtl/anton_neopixel_bus_arbiter.sv
// Round-robin arbiter sharing the neopixel pixel-buffer bus between the APB path (port 0)
// and the pattern engine (port 1), with watchdog-limited locked bursts and 1-cycle read return.
module anton_neopixel_bus_arbiter #(
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic        apbPclk,
  input  logic        apbPresern,
  input  logic        req0,
  input  logic        req1,
  input  logic [13:0] addr0,
  input  logic [13:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic        write0,
  input  logic        write1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        lockErr,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [7:0] LockLast = 8'(LOCK_MAX - 1);

  logic [1:0] stateQ, stateD;
  logic       lastGrantQ, lastGrantD;
  logic [7:0] holdCntQ, holdCntD;
  logic       readPendQ, readPortQ;
  logic [7:0] rdata0Q, rdata1Q;

  logic ownReq, ownLock, ownWrite;
  logic lockActive, lockHold;
  logic winner;

  assign gnt0 = (stateQ == OWN0) && req0;
  assign gnt1 = (stateQ == OWN1) && req1;

  // Bus mux follows the registered owner, independent of its current request.
  always_comb begin
    ownReq    = 1'b0;
    ownLock   = 1'b0;
    ownWrite  = 1'b0;
    busAddr   = '0;
    busDataIn = '0;
    case (stateQ)
      OWN0: begin
        ownReq    = req0;
        ownLock   = lock0;
        ownWrite  = write0;
        busAddr   = addr0;
        busDataIn = wdata0;
      end
      OWN1: begin
        ownReq    = req1;
        ownLock   = lock1;
        ownWrite  = write1;
        busAddr   = addr1;
        busDataIn = wdata1;
      end
      default: ;
    endcase
  end

  assign busWrite = (gnt0 || gnt1) && ownWrite;
  assign busRead  = (gnt0 || gnt1) && !ownWrite;

  assign lockActive = ownReq && ownLock;
  assign lockHold   = lockActive && (holdCntQ < LockLast);
  assign lockErr    = lockActive && (holdCntQ == LockLast);

  always_comb begin
    stateD     = stateQ;
    lastGrantD = lastGrantQ;
    holdCntD   = holdCntQ;
    winner     = 1'b0;
    if (lockHold) begin
      holdCntD = 8'(holdCntQ + 8'd1);
    end else begin
      // On a watchdog release the owner equals lastGrant, so a tie hands over.
      if (req0 && req1) begin
        winner = !lastGrantQ;
      end else begin
        winner = req1;
      end
      holdCntD = '0;
      if (req0 || req1) begin
        stateD     = winner ? OWN1 : OWN0;
        lastGrantD = winner;
      end else begin
        stateD = IDLE;
      end
    end
  end

  always_ff @(posedge apbPclk or negedge apbPresern) begin
    if (!apbPresern) begin
      stateQ     <= IDLE;
      lastGrantQ <= 1'b1;
      holdCntQ   <= '0;
    end else begin
      stateQ     <= stateD;
      lastGrantQ <= lastGrantD;
      holdCntQ   <= holdCntD;
    end
  end

  // Read return: busDataOut is valid the cycle after busRead, routed to the issuing port.
  assign rvalid0 = readPendQ && !readPortQ;
  assign rvalid1 = readPendQ && readPortQ;
  assign rdata0  = rvalid0 ? busDataOut : rdata0Q;
  assign rdata1  = rvalid1 ? busDataOut : rdata1Q;

  always_ff @(posedge apbPclk or negedge apbPresern) begin
    if (!apbPresern) begin
      readPendQ <= 1'b0;
      readPortQ <= 1'b0;
      rdata0Q   <= '0;
      rdata1Q   <= '0;
    end else begin
      readPendQ <= busRead;
      readPortQ <= gnt1;
      if (rvalid0) rdata0Q <= busDataOut;
      if (rvalid1) rdata1Q <= busDataOut;
    end
  end

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// Directed self-checking bench for anton_neopixel_bus_arbiter, built with LOCK_MAX = 4.
module tb_anton_neopixel_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [13:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        write0 = 1'b0, write1 = 1'b0;
  logic        lock0 = 1'b0, lock1 = 1'b0;
  logic        gnt0, gnt1, rvalid0, rvalid1, lockErr, busWrite, busRead;
  logic [7:0]  rdata0, rdata1, busDataIn;
  logic [13:0] busAddr;
  logic [7:0]  busDataOut = 8'h00;

  int total = 0;
  int bad = 0;

  anton_neopixel_bus_arbiter #(.LOCK_MAX(4)) dut (
    .apbPclk(clk), .apbPresern(rstN),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .write0(write0), .write1(write1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .lockErr(lockErr), .busAddr(busAddr), .busDataIn(busDataIn),
    .busWrite(busWrite), .busRead(busRead), .busDataOut(busDataOut)
  );

  always #5 clk = ~clk;

  // Pixel-buffer model: read data is address low byte XOR 0xC0, one cycle after busRead.
  always @(posedge clk) if (busRead) busDataOut <= busAddr[7:0] ^ 8'hC0;

  // Inputs change 1ns after the edge; checks happen 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dropAll();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    tick(); tick();
  endtask

  task automatic doReset();
    rstN = 0;
    tick();
    rstN = 1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({gnt0, gnt1, busWrite, busRead, rvalid0, rvalid1, lockErr} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000000",
                      {gnt0, gnt1, busWrite, busRead, rvalid0, rvalid1, lockErr});
    end
    total++;
    if ({busAddr, busDataIn} !== 22'h0) begin
      bad++; $display("FAIL reset_bus got=%h exp=0", {busAddr, busDataIn});
    end
    total++;
    if ({rdata0, rdata1} !== 16'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", {rdata0, rdata1});
    end
    tick();
    rstN = 1;
    tick();
  endtask

  task automatic test_write();
    req0 = 1; addr0 = 14'h0010; wdata0 = 8'h5A; write0 = 1;
    #1;
    total++;
    if (gnt0 !== 1'b0) begin bad++; $display("FAIL write_t0_gnt got=%b exp=0", gnt0); end
    tick();
    #1;
    total++;
    if ({gnt0, busWrite, busRead} !== 3'b110) begin
      bad++; $display("FAIL write_t1_ctrl got=%b exp=110", {gnt0, busWrite, busRead});
    end
    total++;
    if (busAddr !== 14'h0010) begin
      bad++; $display("FAIL write_addr got=%h exp=0010", busAddr);
    end
    total++;
    if (busDataIn !== 8'h5A) begin bad++; $display("FAIL write_data got=%h exp=5a", busDataIn); end
    tick();
    req0 = 0;
    #1;
    total++;
    if ({gnt0, busWrite} !== 2'b00) begin
      bad++; $display("FAIL write_no_repeat got=%b exp=00", {gnt0, busWrite});
    end
    tick();
    #1;
    total++;
    if ({gnt0, gnt1, busWrite, busRead, busAddr} !== 18'h0) begin
      bad++; $display("FAIL write_idle got=%h exp=0", {gnt0, gnt1, busWrite, busRead, busAddr});
    end
  endtask

  task automatic test_alternate();
    doReset();
    req0 = 1; req1 = 1; write0 = 1; write1 = 0; addr1 = 14'h0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      total++;
      if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL alt_gnt cycle=%0d got=%b exp=%b", i, {gnt0, gnt1},
                        ((i % 2 == 0) ? 2'b10 : 2'b01));
      end
      total++;
      if ((busRead & busWrite) !== 1'b0) begin
        bad++; $display("FAIL alt_rw_excl cycle=%0d got=1 exp=0", i);
      end
    end
    dropAll();
  endtask

  task automatic test_read();
    req0 = 1; addr0 = 14'h0007; write0 = 0;
    tick();
    #1;
    total++;
    if ({gnt0, busRead} !== 2'b11) begin
      bad++; $display("FAIL rd0_gnt got=%b exp=11", {gnt0, busRead});
    end
    tick();
    req0 = 0; req1 = 1; addr1 = 14'h0003; write1 = 0;
    #1;
    total++;
    if ({rvalid0, rdata0} !== {1'b1, 8'hC7}) begin
      bad++; $display("FAIL rd0_return got=%b/%h exp=1/c7", rvalid0, rdata0);
    end
    tick();
    #1;
    total++;
    if ({gnt1, busRead, busAddr} !== {2'b11, 14'h0003}) begin
      bad++; $display("FAIL rd1_gnt got=%b%b/%h exp=11/0003", gnt1, busRead, busAddr);
    end
    tick();
    req1 = 0;
    #1;
    total++;
    if ({rvalid1, rdata1} !== {1'b1, 8'hC3}) begin
      bad++; $display("FAIL rd1_return got=%b/%h exp=1/c3", rvalid1, rdata1);
    end
    total++;
    if ({rvalid0, rdata0} !== {1'b0, 8'hC7}) begin
      bad++; $display("FAIL rd1_other_port got=%b/%h exp=0/c7", rvalid0, rdata0);
    end
    tick();
    #1;
    total++;
    if ({rvalid1, rdata1} !== {1'b0, 8'hC3}) begin
      bad++; $display("FAIL rd1_hold got=%b/%h exp=0/c3", rvalid1, rdata1);
    end
    tick();
  endtask

  task automatic test_watchdog();
    req0 = 1; lock0 = 1; req1 = 1; lock1 = 0; write0 = 1; write1 = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      #1;
      total++;
      if ({gnt0, gnt1, lockErr} !== ((i <= 3) ? 3'b100 : (i == 4) ? 3'b101 : 3'b010)) begin
        bad++; $display("FAIL wdog cycle=%0d got=%b exp=%b", i, {gnt0, gnt1, lockErr},
                        ((i <= 3) ? 3'b100 : (i == 4) ? 3'b101 : 3'b010));
      end
    end
    dropAll();
  endtask

  task automatic test_burst();
    req0 = 1; lock0 = 1; req1 = 1; write0 = 1; write1 = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) lock0 = 0;
      if (i == 4) req0 = 0;
      #1;
      total++;
      if ({gnt0, gnt1, lockErr} !== ((i <= 3) ? 3'b100 : 3'b010)) begin
        bad++; $display("FAIL burst cycle=%0d got=%b exp=%b", i, {gnt0, gnt1, lockErr},
                        ((i <= 3) ? 3'b100 : 3'b010));
      end
    end
    dropAll();
  endtask

  task automatic test_reset_mid();
    req0 = 1; addr0 = 14'h0005; write0 = 0;
    tick();
    #1;
    total++;
    if ({gnt0, busRead} !== 2'b11) begin
      bad++; $display("FAIL rst_mid_gnt got=%b exp=11", {gnt0, busRead});
    end
    tick();
    req0 = 0;
    rstN = 0;
    #1;
    total++;
    if ({gnt0, gnt1, busWrite, busRead, rvalid0, rvalid1, lockErr, rdata0, rdata1, busAddr}
        !== 37'h0) begin
      bad++; $display("FAIL rst_mid_outputs got=%b%b%b%b%b%b%b/%h/%h/%h exp=0",
                      gnt0, gnt1, busWrite, busRead, rvalid0, rvalid1, lockErr,
                      rdata0, rdata1, busAddr);
    end
    tick();
    rstN = 1;
    tick();
    #1;
    total++;
    if ({rvalid0, rvalid1, rdata0} !== 10'h0) begin
      bad++; $display("FAIL rst_mid_no_rvalid got=%b%b/%h exp=00/00", rvalid0, rvalid1, rdata0);
    end
    req0 = 1; req1 = 1; write0 = 1; write1 = 1;
    tick();
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++; $display("FAIL rst_mid_first_tie got=%b exp=10", {gnt0, gnt1});
    end
    dropAll();
  endtask

  initial begin
    test_reset();
    test_write();
    test_alternate();
    test_read();
    test_watchdog();
    test_burst();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
